// File: rtl/fc_lif_stream_layer.sv
// Fully-connected + leaky-integrate-and-fire layer.
// Streams INPUT_NODES signed beats per time step and multiply-accumulates each
// beat against a row of packed weights from an external ROM with a one-cycle
// read. It then applies one leak/integrate/fire update to every neuron and
// keeps per-frame spike counts over STEP time steps.
module fc_lif_stream_layer #(
  parameter int WIDTH        = 24,
  parameter int FRAC         = 17,
  parameter int STEP         = 25,
  parameter int INPUT_NODES  = 784,
  parameter int OUTPUT_NODES = 20,
  parameter int LEAK_SHIFT   = 1,
  parameter int RESET_MODE   = 0,
  parameter int CNT_W        = $clog2(STEP + 1),
  parameter int AW           = (INPUT_NODES > 1) ? $clog2(INPUT_NODES) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            in_valid,
  input  logic [WIDTH-1:0]                in_data,
  output logic                            in_ready,
  output logic [AW-1:0]                   w_addr,
  input  logic [OUTPUT_NODES*WIDTH-1:0]   w_data,
  input  logic [WIDTH-1:0]                threshold,
  output logic                            busy,
  output logic [OUTPUT_NODES-1:0]         spk_out,
  output logic                            step_done,
  output logic                            frame_done,
  output logic [CNT_W-1:0]                step_idx,
  output logic [OUTPUT_NODES*CNT_W-1:0]   spk_count
);

  // Intermediate sums are held with enough headroom that a full-range
  // product plus a full-range accumulator never wraps before clamping.
  localparam int XW = 2 * WIDTH + 2;
  localparam logic signed [XW-1:0] SAT_MAX_X = {{(XW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN_X = {{(XW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACC    = 3'd1,
    S_DRAIN1 = 3'd2,
    S_DRAIN2 = 3'd3,
    S_FIRE   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0]                  addr_q;
  logic signed [WIDTH-1:0]        x_q;
  logic                           v1_q, v2_q;
  logic signed [2*WIDTH-1:0]      p_q      [OUTPUT_NODES];
  logic signed [2*WIDTH-1:0]      prod_d   [OUTPUT_NODES];
  logic signed [WIDTH-1:0]        acc_q    [OUTPUT_NODES];
  logic signed [WIDTH-1:0]        acc_d    [OUTPUT_NODES];
  logic signed [WIDTH-1:0]        mem_q    [OUTPUT_NODES];
  logic signed [WIDTH-1:0]        mem_d    [OUTPUT_NODES];
  logic [CNT_W-1:0]               cnt_q    [OUTPUT_NODES];
  logic [OUTPUT_NODES-1:0]        spike_d;
  logic [OUTPUT_NODES-1:0]        spk_q;
  logic [CNT_W-1:0]               step_q;
  logic                           step_done_q, frame_done_q;
  logic signed [WIDTH-1:0]        thr_s;

  logic accept, last_beat, step_start;

  function automatic logic signed [XW-1:0] sext_w(input logic signed [WIDTH-1:0] a);
    return {{(XW-WIDTH){a[WIDTH-1]}}, a};
  endfunction

  function automatic logic signed [XW-1:0] sext_p(input logic signed [2*WIDTH-1:0] a);
    return {{(XW-2*WIDTH){a[2*WIDTH-1]}}, a};
  endfunction

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
    if (v > SAT_MAX_X)      return {1'b0, {(WIDTH-1){1'b1}}};
    else if (v < SAT_MIN_X) return {1'b1, {(WIDTH-1){1'b0}}};
    else                    return v[WIDTH-1:0];
  endfunction

  assign thr_s      = threshold;
  assign accept     = in_valid && (state_q == S_ACC);
  assign last_beat  = accept && (addr_q == AW'(INPUT_NODES - 1));
  assign step_start = start && (state_q == S_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: the two drain cycles let the last product reach acc
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_ACC;
      S_ACC:    if (last_beat) state_d = S_DRAIN1;
      S_DRAIN1: state_d = S_DRAIN2;
      S_DRAIN2: state_d = S_FIRE;
      S_FIRE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Handshake/status outputs decoded from the current state
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    case (state_q)
      S_IDLE:  busy     = 1'b0;
      S_ACC:   in_ready = 1'b1;
      default: ;
    endcase
  end

  // Per-neuron MAC and LIF arithmetic
  genvar gi;
  generate
    for (gi = 0; gi < OUTPUT_NODES; gi++) begin : g_neuron
      logic signed [WIDTH-1:0]   w_j;
      logic signed [2*WIDTH-1:0] prod_full;
      logic signed [WIDTH-1:0]   leak_j, v_j, soft_j;

      assign w_j         = w_data[gi*WIDTH +: WIDTH];
      assign prod_full   = x_q * w_j;
      assign prod_d[gi]  = prod_full >>> FRAC;
      assign acc_d[gi]   = sat(sext_p(p_q[gi]) + sext_w(acc_q[gi]));
      assign leak_j      = sat(sext_w(mem_q[gi]) - sext_w(mem_q[gi] >>> LEAK_SHIFT));
      assign v_j         = sat(sext_w(leak_j) + sext_w(acc_q[gi]));
      assign spike_d[gi] = (v_j >= thr_s);
      assign soft_j      = sat(sext_w(v_j) - sext_w(thr_s));
      assign mem_d[gi]   = spike_d[gi] ? ((RESET_MODE != 0) ? soft_j : '0) : v_j;
      assign spk_count[gi*CNT_W +: CNT_W] = cnt_q[gi];
    end
  endgenerate

  // Datapath: beat capture, product/accumulate pipeline, fire update, counters
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= '0;
      x_q          <= '0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      spk_q        <= '0;
      step_q       <= '0;
      step_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int j = 0; j < OUTPUT_NODES; j++) begin
        p_q[j]   <= '0;
        acc_q[j] <= '0;
        mem_q[j] <= '0;
        cnt_q[j] <= '0;
      end
    end else begin
      step_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      v1_q         <= accept;
      v2_q         <= v1_q;
      if (accept) begin
        x_q    <= in_data;
        addr_q <= last_beat ? '0 : addr_q + AW'(1);
      end else if (step_start) begin
        addr_q <= '0;
      end
      for (int j = 0; j < OUTPUT_NODES; j++) begin
        if (v1_q) p_q[j] <= prod_d[j];
        if (step_start) begin
          acc_q[j] <= '0;
          // First step of a frame starts from a fresh membrane and count
          if (step_q == '0) begin
            mem_q[j] <= '0;
            cnt_q[j] <= '0;
          end
        end else if (v2_q) begin
          acc_q[j] <= acc_d[j];
        end
        if (state_q == S_FIRE) begin
          mem_q[j] <= mem_d[j];
          cnt_q[j] <= cnt_q[j] + CNT_W'(spike_d[j]);
        end
      end
      if (state_q == S_FIRE) begin
        spk_q       <= spike_d;
        step_done_q <= 1'b1;
        if (step_q == CNT_W'(STEP - 1)) begin
          step_q       <= '0;
          frame_done_q <= 1'b1;
        end else begin
          step_q <= step_q + CNT_W'(1);
        end
      end
    end
  end

  assign w_addr     = addr_q;
  assign spk_out    = spk_q;
  assign step_done  = step_done_q;
  assign frame_done = frame_done_q;
  assign step_idx   = step_q;

endmodule

// File: tb/tb_fc_lif_stream_layer.sv
// Directed bench: a hard-reset and a soft-reset instance share all stimulus
// and are checked against hand-computed Q6.17 values.
module tb_fc_lif_stream_layer;
  localparam int W  = 24;
  localparam int IN = 4;
  localparam int ON = 2;
  localparam int CW = 2;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic reset, start, in_valid;
  logic [W-1:0] in_data, threshold;

  logic in_ready_h, busy_h, step_done_h, frame_done_h;
  logic in_ready_s, busy_s, step_done_s, frame_done_s;
  logic [AW-1:0] w_addr_h, w_addr_s;
  logic [ON*W-1:0] w_data_h, w_data_s;
  logic [ON-1:0] spk_out_h, spk_out_s;
  logic [CW-1:0] step_idx_h, step_idx_s;
  logic [ON*CW-1:0] spk_count_h, spk_count_s;

  logic [ON*W-1:0] rom_h [IN];
  logic [ON*W-1:0] rom_s [IN];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // External weight ROMs with one-cycle registered read
  always @(posedge clk) begin
    w_data_h <= rom_h[w_addr_h];
    w_data_s <= rom_s[w_addr_s];
  end

  fc_lif_stream_layer #(.WIDTH(W), .FRAC(17), .STEP(3), .INPUT_NODES(IN),
    .OUTPUT_NODES(ON), .LEAK_SHIFT(1), .RESET_MODE(0)) dut_h (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_h), .w_addr(w_addr_h), .w_data(w_data_h), .threshold(threshold),
    .busy(busy_h), .spk_out(spk_out_h), .step_done(step_done_h), .frame_done(frame_done_h),
    .step_idx(step_idx_h), .spk_count(spk_count_h));

  fc_lif_stream_layer #(.WIDTH(W), .FRAC(17), .STEP(3), .INPUT_NODES(IN),
    .OUTPUT_NODES(ON), .LEAK_SHIFT(1), .RESET_MODE(1)) dut_s (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_s), .w_addr(w_addr_s), .w_data(w_data_s), .threshold(threshold),
    .busy(busy_s), .spk_out(spk_out_s), .step_done(step_done_s), .frame_done(frame_done_s),
    .step_idx(step_idx_s), .spk_count(spk_count_s));

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One time step: start pulse, IN beats gated by mask, optional start/in_valid
  // poke during the drain, returns at the step_done cycle (or budget expiry).
  task automatic run_step(input logic [7:0] mask, input bit poke,
                          input logic [W-1:0] x, input string nm);
    int beat, cyc, lat;
    bit gap_pend;
    logic [AW-1:0] held;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    beat = 0; cyc = 0; gap_pend = 1'b0; held = '0;
    while (beat < IN && cyc < 64) begin
      if (gap_pend) check({nm, ".waddr_hold"}, W'(w_addr_h), W'(held));
      in_valid = mask[cyc % 8];
      in_data  = x;
      if (!in_valid) begin
        gap_pend = 1'b1;
        held     = w_addr_h;
      end else begin
        gap_pend = 1'b0;
        if (in_ready_h) beat++;
      end
      @(negedge clk); cyc++;
    end
    check({nm, ".beats"}, W'(beat), W'(IN));
    lat = 1;
    in_valid = poke; start = poke;
    while (!step_done_h && lat < 20) begin
      @(negedge clk); lat++;
      if (lat >= 3) begin in_valid = 1'b0; start = 1'b0; end
    end
    in_valid = 1'b0; start = 1'b0;
    check({nm, ".latency"}, W'(lat), W'(4));
    check({nm, ".step_done_s"}, W'(step_done_s), W'(1));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    threshold = 24'h010000;                         // 0.5
    for (int k = 0; k < IN; k++) begin
      rom_h[k] = {24'h000000, 24'h008000};          // n0 0.25, n1 0
      rom_s[k] = {24'h004000, (k < 3) ? 24'h008000 : 24'h000000}; // n0 sum 0.75, n1 0.125
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst.busy",      W'(busy_h),      W'(0));
    check("rst.in_ready",  W'(in_ready_h),  W'(0));
    check("rst.spk_out",   W'(spk_out_h),   W'(0));
    check("rst.step_idx",  W'(step_idx_h),  W'(0));
    check("rst.spk_count", W'(spk_count_s), W'(0));
    check("rst.step_done", W'(step_done_s), W'(0));

    // Step 0: no gaps
    run_step(8'hFF, 1'b0, 24'h020000, "A");
    check("A.spk_h",   W'(spk_out_h), W'(2'b01));
    check("A.spk_s",   W'(spk_out_s), W'(2'b11));
    check("A.acc_h0",  dut_h.acc_q[0], 24'h020000);
    check("A.acc_s0",  dut_s.acc_q[0], 24'h018000);
    check("A.acc_s1",  dut_s.acc_q[1], 24'h010000);
    check("A.mem_h0",  dut_h.mem_q[0], 24'h000000);
    check("A.mem_s0",  dut_s.mem_q[0], 24'h008000);
    check("A.step_idx", W'(step_idx_h), W'(1));
    check("A.frame",   W'(frame_done_h), W'(0));
    check("A.cnt_h",   W'(spk_count_h), W'(4'b0001));
    check("A.cnt_s",   W'(spk_count_s), W'(4'b0101));

    // Step 1: valid gaps, plus start/in_valid asserted during drain
    run_step(8'b1001_0110, 1'b1, 24'h020000, "B");
    check("B.spk_h",   W'(spk_out_h), W'(2'b01));
    check("B.spk_s",   W'(spk_out_s), W'(2'b11));
    check("B.acc_h0",  dut_h.acc_q[0], 24'h020000);
    check("B.mem_h0",  dut_h.mem_q[0], 24'h000000);
    check("B.mem_s0",  dut_s.mem_q[0], 24'h00C000);
    check("B.mem_s1",  dut_s.mem_q[1], 24'h000000);
    check("B.step_idx", W'(step_idx_s), W'(2));
    check("B.frame",   W'(frame_done_s), W'(0));
    check("B.cnt_h",   W'(spk_count_h), W'(4'b0010));
    check("B.cnt_s",   W'(spk_count_s), W'(4'b1010));
    @(negedge clk);
    check("B.idle_after", W'(busy_h), W'(0));

    // Step 2: last step of the frame
    run_step(8'hFF, 1'b0, 24'h020000, "C");
    check("C.frame_h", W'(frame_done_h), W'(1));
    check("C.frame_s", W'(frame_done_s), W'(1));
    check("C.step_idx", W'(step_idx_h), W'(0));
    check("C.cnt_h",   W'(spk_count_h), W'(4'b0011));
    check("C.cnt_s",   W'(spk_count_s), W'(4'b1111));
    check("C.mem_s0",  dut_s.mem_q[0], 24'h00E000);
    @(negedge clk);
    check("C.frame_pulse", W'(frame_done_h), W'(0));
    repeat (3) @(negedge clk);
    check("C.cnt_hold", W'(spk_count_h), W'(4'b0011));

    // Next frame start clears counts and membranes, then reset mid-ACC
    start = 1'b1; @(negedge clk); start = 1'b0;
    check("D.cnt_clr_h", W'(spk_count_h), W'(0));
    check("D.cnt_clr_s", W'(spk_count_s), W'(0));
    check("D.mem_clr",   dut_s.mem_q[0], 24'h000000);
    check("D.in_ready",  W'(in_ready_h), W'(1));
    in_valid = 1'b1; in_data = 24'h020000;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    check("D.rst_busy",  W'(busy_h),     W'(0));
    check("D.rst_ready", W'(in_ready_s), W'(0));
    check("D.rst_acc",   dut_h.acc_q[0], 24'h000000);
    check("D.rst_mem",   dut_s.mem_q[0], 24'h000000);
    check("D.rst_spk",   W'(spk_out_s),  W'(0));

    // Saturation at both extremes
    for (int k = 0; k < IN; k++) begin
      rom_h[k] = {24'h800000, 24'h7FFFFF};
      rom_s[k] = {24'h800000, 24'h7FFFFF};
    end
    run_step(8'hFF, 1'b0, 24'h7FFFFF, "E");
    check("E.acc_h0", dut_h.acc_q[0], 24'h7FFFFF);
    check("E.acc_h1", dut_h.acc_q[1], 24'h800000);
    check("E.spk_h",  W'(spk_out_h), W'(2'b01));
    check("E.mem_h1", dut_h.mem_q[1], 24'h800000);
    check("E.spk_s",  W'(spk_out_s), W'(2'b01));
    check("E.mem_s0", dut_s.mem_q[0], 24'h7EFFFF);
    check("E.step_idx", W'(step_idx_h), W'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
